// File: rtl/axis_match_monitor.sv
// rtl/axis_match_monitor.sv - passive AXI4-Stream first-beat pattern monitor with armed/timeout window
//
// Optional feature macro: AXIS_MATCH_MON_PROTO_CHECK_EN adds the sticky proto_err output.
//
// Ports:
//   axis_aclk, aresetn                 clock, synchronous active-low reset
//   s_axis_tdata/tkeep/tvalid/tready/tlast  tapped stream (all inputs, never driven)
//   cfg_wr_en/idx/data/mask/enable     slot configuration write port
//   arm, clear, timeout_cycles         window control
//   hit_flags, hit_count, first_hit_idx  per-slot statistics
//   done, timed_out, state             window state (IDLE=0 ARMED=1 DONE=2 TIMEOUT=3)
//   proto_err                          sticky tkeep protocol error (macro builds only)

module axis_match_monitor #(
  parameter int DATA_W      = 512,
  parameter int NUM_TARGETS = 4,
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 32
) (
  input  logic                                                    axis_aclk,
  input  logic                                                    aresetn,
  input  logic [DATA_W-1:0]                                       s_axis_tdata,
  input  logic [DATA_W/8-1:0]                                     s_axis_tkeep,
  input  logic                                                    s_axis_tvalid,
  input  logic                                                    s_axis_tready,
  input  logic                                                    s_axis_tlast,
  input  logic                                                    cfg_wr_en,
  input  logic [(NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1)-1:0] cfg_wr_idx,
  input  logic [DATA_W-1:0]                                       cfg_wr_data,
  input  logic [DATA_W-1:0]                                       cfg_wr_mask,
  input  logic                                                    cfg_wr_enable,
  input  logic                                                    arm,
  input  logic                                                    clear,
  input  logic [TMO_W-1:0]                                        timeout_cycles,
  output logic [NUM_TARGETS-1:0]                                  hit_flags,
  output logic [NUM_TARGETS*CNT_W-1:0]                            hit_count,
  output logic [(NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1)-1:0] first_hit_idx,
  output logic                                                    done,
  output logic                                                    timed_out,
`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
  output logic                                                    proto_err,
`endif
  output logic [1:0]                                              state
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  logic [DATA_W-1:0]            r_pat  [NUM_TARGETS];
  logic [DATA_W-1:0]            r_mask [NUM_TARGETS];
  logic [NUM_TARGETS-1:0]       r_en;
  logic                         r_sop;
  logic [1:0]                   r_state;
  logic [1:0]                   w_state_next;
  logic [TMO_W-1:0]             r_timer;
  logic                         r_no_tmo;
  logic [NUM_TARGETS-1:0]       r_hit_flags;
  logic [NUM_TARGETS*CNT_W-1:0] r_hit_count;
  logic [IDX_W-1:0]             r_first_idx;

  logic                         w_xfer;
  logic [DATA_W-1:0]            w_keep_bits;
  logic [NUM_TARGETS-1:0]       w_match;
  logic [NUM_TARGETS-1:0]       w_flags_next;
  logic [IDX_W-1:0]             w_low_idx;
  logic                         w_all_hit;
  logic                         w_expired;
  logic                         w_armed;
  logic                         w_start;

  assign w_xfer  = s_axis_tvalid & s_axis_tready;
  assign w_armed = (r_state == S_ARMED);
  // arm is ignored while a window is open, and clear always wins.
  assign w_start = arm & ~clear & ~w_armed;

  for (genvar b = 0; b < KEEP_W; b++) begin : g_keep
    assign w_keep_bits[b*8 +: 8] = {8{s_axis_tkeep[b]}};
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      w_match[i] = w_xfer & r_sop & r_en[i] &
                   (((s_axis_tdata ^ r_pat[i]) & r_mask[i] & w_keep_bits) == '0);
    end
  end

  // Lowest matching index: scan downward so the last assignment is the lowest.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (w_match[i]) w_low_idx = IDX_W'(i);
    end
  end

  assign w_flags_next = r_hit_flags | w_match;
  // An empty enabled set must never count as "all hit".
  assign w_all_hit    = (r_en != '0) && ((w_flags_next & r_en) == r_en);
  // The timer is loaded with T-1, so reaching 0 here means the window is used up.
  assign w_expired    = ~r_no_tmo & (r_timer == '0);

  // FSM: state register
  always_ff @(posedge axis_aclk) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_all_hit)      w_state_next = S_DONE;
          else if (w_expired) w_state_next = S_TIMEOUT;
        end
        default: begin
          if (arm) w_state_next = S_ARMED;
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state     = r_state;
    done      = (r_state == S_DONE);
    timed_out = (r_state == S_TIMEOUT);
  end

  always_ff @(posedge axis_aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        r_pat[i]  <= '0;
        r_mask[i] <= '0;
      end
      r_en        <= '0;
      r_sop       <= 1'b1;
      r_timer     <= '0;
      r_no_tmo    <= 1'b0;
      r_hit_flags <= '0;
      r_hit_count <= '0;
      r_first_idx <= '0;
    end else begin
      // Beats in the write cycle see the old slot contents.
      if (cfg_wr_en && (int'(cfg_wr_idx) < NUM_TARGETS)) begin
        r_pat[cfg_wr_idx]  <= cfg_wr_data;
        r_mask[cfg_wr_idx] <= cfg_wr_mask;
        r_en[cfg_wr_idx]   <= cfg_wr_enable;
      end

      if (clear)       r_sop <= 1'b1;
      else if (w_xfer) r_sop <= s_axis_tlast;

      if (clear || w_start) begin
        r_hit_flags <= '0;
        r_hit_count <= '0;
        r_first_idx <= '0;
        if (w_start) begin
          r_no_tmo <= (timeout_cycles == '0);
          r_timer  <= (timeout_cycles == '0) ? '0 : timeout_cycles - TMO_W'(1);
        end
      end else if (w_armed) begin
        r_hit_flags <= w_flags_next;
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (w_match[i] && (r_hit_count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
            r_hit_count[i*CNT_W +: CNT_W] <= r_hit_count[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
        if ((r_hit_flags == '0) && (w_match != '0)) r_first_idx <= w_low_idx;
        if (r_timer != '0) r_timer <= r_timer - TMO_W'(1);
      end
    end
  end

  assign hit_flags     = r_hit_flags;
  assign hit_count     = r_hit_count;
  assign first_hit_idx = r_first_idx;

`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
  logic w_keep_contig;
  logic r_proto_err;

  // Contiguous from byte 0 (2^k-1, k>=1): adding one clears every set bit.
  assign w_keep_contig = (s_axis_tkeep != '0) &&
                         ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) == '0);

  always_ff @(posedge axis_aclk) begin
    if (!aresetn || clear) begin
      r_proto_err <= 1'b0;
    end else if (w_xfer && (s_axis_tlast ? !w_keep_contig : (s_axis_tkeep != '1))) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_axis_match_monitor.sv
// tb/tb_axis_match_monitor.sv - directed self-checking bench for axis_match_monitor

module tb_axis_match_monitor;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int NT = 4;
  localparam int CW = 4;
  localparam int TW = 32;

  localparam logic [DW-1:0] FULL  = {DW{1'b1}};
  localparam logic [DW-1:0] UP64  = {64'hFFFF_FFFF_FFFF_FFFF, 448'd0};
  localparam logic [KW-1:0] KALL  = {KW{1'b1}};
  localparam logic [DW-1:0] PAT_A = {16{32'hA5A5_0001}};
  localparam logic [DW-1:0] PAT_P = {16{32'h1234_5678}};
  localparam logic [DW-1:0] PAT_Q = {16{32'hCAFE_F00D}};
  localparam logic [DW-1:0] PAT_X = {16{32'h0BAD_BEEF}};
  localparam logic [DW-1:0] PAT_M = {16{32'h5EED_0042}};
  localparam logic [DW-1:0] PAT_K = {16{32'h7777_1111}};
  localparam logic [DW-1:0] PAT_S = {16{32'h3C3C_9999}};
  localparam logic [DW-1:0] PAT_N = {16{32'hDEAD_0007}};

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic          tvalid = 1'b0;
  logic          tready = 1'b0;
  logic          tlast = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [1:0]    cfg_wr_idx = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [DW-1:0] cfg_wr_mask = '0;
  logic          cfg_wr_enable = 1'b0;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic [TW-1:0] timeout_cycles = '0;
  logic [NT-1:0] hit_flags;
  logic [NT*CW-1:0] hit_count;
  logic [1:0]    first_hit_idx;
  logic          done;
  logic          timed_out;
  logic [1:0]    state;
`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
  logic          proto_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_match_monitor #(.DATA_W(DW), .NUM_TARGETS(NT), .CNT_W(CW), .TMO_W(TW)) dut (
    .axis_aclk      (clk),
    .aresetn        (aresetn),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tlast   (tlast),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_idx     (cfg_wr_idx),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_mask    (cfg_wr_mask),
    .cfg_wr_enable  (cfg_wr_enable),
    .arm            (arm),
    .clear          (clear),
    .timeout_cycles (timeout_cycles),
    .hit_flags      (hit_flags),
    .hit_count      (hit_count),
    .first_hit_idx  (first_hit_idx),
    .done           (done),
    .timed_out      (timed_out),
`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
    .proto_err      (proto_err),
`endif
    .state          (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic en);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_data = d; cfg_wr_mask = m; cfg_wr_enable = en;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1; tready = 1'b1;
    tick();
    tvalid = 1'b0;
  endtask

  task automatic do_arm(input logic [TW-1:0] t);
    arm = 1'b1; timeout_cycles = t;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (hit_flags !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", hit_flags); end
    n_checks++; if (hit_count !== 16'h0) begin n_errors++; $display("FAIL reset_count: got %h want 0000", hit_count); end
    n_checks++; if ({done, timed_out, first_hit_idx} !== 4'b0) begin n_errors++;
      $display("FAIL reset_misc: got done=%b tmo=%b idx=%0d want 0 0 0", done, timed_out, first_hit_idx); end
  endtask

  task automatic test_single_hit();
    cfg_write(2'd0, PAT_A, FULL, 1'b1);
    do_arm(32'd100);
    n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL single_armed: got %0d want 1", state); end
    send_beat(PAT_A, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0001) begin n_errors++; $display("FAIL single_flags: got %b want 0001", hit_flags); end
    n_checks++; if (hit_count[3:0] !== 4'd1) begin n_errors++; $display("FAIL single_count: got %0d want 1", hit_count[3:0]); end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL single_done: got %b want 1", done); end
    n_checks++; if (first_hit_idx !== 2'd0) begin n_errors++; $display("FAIL single_idx: got %0d want 0", first_hit_idx); end
  endtask

  task automatic test_sop();
    cfg_write(2'd0, PAT_P, FULL, 1'b1);
    cfg_write(2'd1, PAT_Q, FULL, 1'b1);
    do_arm(32'd0);
    n_checks++; if (hit_flags !== 4'b0 || hit_count !== 16'h0) begin n_errors++;
      $display("FAIL rearm_zero: got flags=%b count=%h want 0000 0000", hit_flags, hit_count); end
    send_beat(PAT_X, KALL, 1'b0);
    send_beat(PAT_P, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0) begin n_errors++; $display("FAIL sop_second_beat: got %b want 0000", hit_flags); end
    send_beat(PAT_Q, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0010) begin n_errors++; $display("FAIL sop_q_flags: got %b want 0010", hit_flags); end
    n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL sop_q_state: got %0d want 1", state); end
    n_checks++; if (first_hit_idx !== 2'd1) begin n_errors++; $display("FAIL sop_q_idx: got %0d want 1", first_hit_idx); end
    send_beat(PAT_P, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0011 || done !== 1'b1) begin n_errors++;
      $display("FAIL sop_p_done: got flags=%b done=%b want 0011 1", hit_flags, done); end
    n_checks++; if (first_hit_idx !== 2'd1) begin n_errors++; $display("FAIL sop_idx_held: got %0d want 1", first_hit_idx); end
  endtask

  task automatic test_mask_keep();
    do_clear();
    cfg_write(2'd1, PAT_Q, FULL, 1'b0);
    cfg_write(2'd0, PAT_M, UP64, 1'b1);
    cfg_write(2'd2, PAT_K, FULL, 1'b1);
    do_arm(32'd0);
    send_beat(PAT_M ^ {64'h1, 448'd0}, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0) begin n_errors++; $display("FAIL mask_upper_diff: got %b want 0000", hit_flags); end
    send_beat(PAT_M ^ {448'd0, 64'h00FF_00FF_1234_55AA}, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0001) begin n_errors++; $display("FAIL mask_low_diff: got %b want 0001", hit_flags); end
    send_beat(PAT_K ^ {504'd0, 8'hFF}, KALL ^ 64'h1, 1'b1);
    n_checks++; if (hit_flags !== 4'b0101 || done !== 1'b1) begin n_errors++;
      $display("FAIL keep_dontcare: got flags=%b done=%b want 0101 1", hit_flags, done); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_clear();
    do_arm(32'd10);
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) send_beat(PAT_M, KALL, 1'b1);
      else        tick();
      if (k < 10 && timed_out !== 1'b0) early++;
    end
    n_checks++; if (early != 0) begin n_errors++; $display("FAIL timeout_early: got %0d early cycles want 0", early); end
    n_checks++; if (timed_out !== 1'b1 || state !== 2'd3) begin n_errors++;
      $display("FAIL timeout_edge: got tmo=%b state=%0d want 1 3", timed_out, state); end
    n_checks++; if (hit_flags !== 4'b0001) begin n_errors++; $display("FAIL timeout_frozen: got %b want 0001", hit_flags); end
    do_clear();
    n_checks++; if (state !== 2'd0 || timed_out !== 1'b0 || done !== 1'b0) begin n_errors++;
      $display("FAIL clear_state: got state=%0d tmo=%b done=%b want 0 0 0", state, timed_out, done); end
    n_checks++; if (hit_flags !== 4'b0 || hit_count !== 16'h0) begin n_errors++;
      $display("FAIL clear_stats: got flags=%b count=%h want 0000 0000", hit_flags, hit_count); end
  endtask

  task automatic test_no_timeout();
    do_arm(32'd0);
    for (int k = 0; k < 40; k++) tick();
    n_checks++; if (state !== 2'd1) begin n_errors++; $display("FAIL no_timeout: got %0d want 1", state); end
    do_clear();
  endtask

  task automatic test_backpressure_saturate();
    cfg_write(2'd2, PAT_K, FULL, 1'b0);
    cfg_write(2'd0, PAT_S, FULL, 1'b1);
    cfg_write(2'd1, PAT_Q, FULL, 1'b1);
    do_arm(32'd0);
    tdata = PAT_S; tkeep = KALL; tlast = 1'b1; tvalid = 1'b1; tready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    tvalid = 1'b0;
    n_checks++; if (hit_flags !== 4'b0 || hit_count[3:0] !== 4'd0) begin n_errors++;
      $display("FAIL no_ready: got flags=%b count=%0d want 0000 0", hit_flags, hit_count[3:0]); end
    for (int k = 1; k <= 19; k++) begin
      send_beat(PAT_S, KALL, 1'b1);
      if (k == 14) begin
        n_checks++; if (hit_count[3:0] !== 4'd14) begin n_errors++; $display("FAIL count_14: got %0d want 14", hit_count[3:0]); end
      end
    end
    n_checks++; if (hit_count[3:0] !== 4'd15) begin n_errors++; $display("FAIL count_sat: got %0d want 15", hit_count[3:0]); end
    n_checks++; if (hit_flags !== 4'b0001 || state !== 2'd1) begin n_errors++;
      $display("FAIL sat_state: got flags=%b state=%0d want 0001 1", hit_flags, state); end
    do_arm(32'd5);
    n_checks++; if (hit_count[3:0] !== 4'd15 || state !== 2'd1) begin n_errors++;
      $display("FAIL arm_ignored: got count=%0d state=%0d want 15 1", hit_count[3:0], state); end
  endtask

  task automatic test_cfg_same_cycle();
    do_clear();
    cfg_write(2'd1, PAT_Q, FULL, 1'b0);
    do_arm(32'd0);
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_data = PAT_N; cfg_wr_mask = FULL; cfg_wr_enable = 1'b1;
    send_beat(PAT_N, KALL, 1'b1);
    cfg_wr_en = 1'b0;
    n_checks++; if (hit_flags !== 4'b0) begin n_errors++; $display("FAIL cfg_old_value: got %b want 0000", hit_flags); end
    send_beat(PAT_N, KALL, 1'b1);
    n_checks++; if (hit_flags !== 4'b0001 || done !== 1'b1) begin n_errors++;
      $display("FAIL cfg_new_value: got flags=%b done=%b want 0001 1", hit_flags, done); end
  endtask

  task automatic test_done_priority();
    do_clear();
    do_arm(32'd3);
    tick();
    tick();
    send_beat(PAT_N, KALL, 1'b1);
    n_checks++; if (state !== 2'd2 || timed_out !== 1'b0) begin n_errors++;
      $display("FAIL done_over_timeout: got state=%0d tmo=%b want 2 0", state, timed_out); end
  endtask

`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
  task automatic test_proto();
    do_clear();
    send_beat(PAT_X, 64'h7, 1'b1);
    send_beat(PAT_X, KALL, 1'b0);
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL proto_good: got %b want 0", proto_err); end
    send_beat(PAT_X, 64'h0FFF_FFFF_FFFF_FFF0, 1'b0);
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL proto_bad: got %b want 1", proto_err); end
    do_clear();
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL proto_clear: got %b want 0", proto_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_sop();
    test_mask_keep();
    test_timeout();
    test_no_timeout();
    test_backpressure_saturate();
    test_cfg_same_cycle();
    test_done_priority();
`ifdef AXIS_MATCH_MON_PROTO_CHECK_EN
    test_proto();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
